// File: rtl/fp_add_pkg.sv
// Shared definitions for the single-precision adder back end: default widths,
// the add/normalise FSM encoding and the field layout of the aligned operand bus.
package fp_add_pkg;

    localparam int MANT_W_DFLT = 23;
    localparam int EXP_W_DFLT  = 8;
    localparam int EXP_MAX     = 255;

    // Field positions inside {semn1, mant1[23:0], semn2, mant2[23:0]}
    localparam int SEMN1_POS = 49;
    localparam int MANT1_HI  = 48;
    localparam int MANT1_LO  = 25;
    localparam int SEMN2_POS = 24;
    localparam int MANT2_HI  = 23;
    localparam int MANT2_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mant_addsub.sv
// Sign-magnitude add/subtract of two aligned mantissas; the magnitude carries
// one extra bit so a same-sign carry-out is visible to the normaliser.
module mant_addsub
    import fp_add_pkg::*;
#(
    parameter int MANT_W = MANT_W_DFLT
) (
    input  logic              semn1,
    input  logic [MANT_W:0]   mant1,
    input  logic              semn2,
    input  logic [MANT_W:0]   mant2,
    output logic              sign,
    output logic [MANT_W+1:0] mag
);

    always_comb begin
        sign = semn1;
        mag  = '0;
        if (semn1 == semn2) begin
            mag = {1'b0, mant1} + {1'b0, mant2};
        end else if (mant1 >= mant2) begin
            mag = {1'b0, mant1} - {1'b0, mant2};
        end else begin
            mag  = {1'b0, mant2} - {1'b0, mant1};
            sign = semn2;
        end
    end

endmodule

// File: rtl/add_norm_mant.sv
// Floating-point adder back end: sign-magnitude add of aligned mantissas,
// one-shift-per-clock normalisation and packing into an IEEE-754 word.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// ADD   | one cycle: add/subtract, carry handling, special exponents
// NORM  | left-shift one bit per clock until the hidden bit is set or flush
// DONE  | rezultat valid, held until out_ready
module add_norm_mant
    import fp_add_pkg::*;
#(
    parameter int MANT_W = MANT_W_DFLT,
    parameter int EXP_W  = EXP_W_DFLT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*(MANT_W+2)-1:0]   mantise_alin,
    input  logic [EXP_W-1:0]          exp_mare,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [EXP_W+MANT_W:0]     rezultat,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int MW    = MANT_W + 1;
    localparam int IW    = 2 * (MANT_W + 2);
    localparam int S1    = IW - 1;
    localparam int M1_HI = IW - 2;
    localparam int M1_LO = MANT_W + 2;
    localparam int S2    = MANT_W + 1;
    localparam int M2_HI = MANT_W;
    localparam int SHW   = $clog2(MANT_W + 1);

    localparam logic [EXP_W-1:0]  EXP_INF   = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(1);
    localparam logic [MANT_W-1:0] FRAC_ZERO = '0;
    localparam logic [SHW-1:0]    SHIFT_MAX = SHW'(MANT_W);
    localparam logic [SHW-1:0]    SHIFT_ONE = SHW'(1);

    state_t                 state;
    logic [IW-1:0]          op_r;
    logic [EXP_W-1:0]       exp_in_r;
    logic [EXP_W-1:0]       exp_r;
    logic [MW-1:0]          mant_r;
    logic                   sign_r;
    logic [SHW-1:0]         shift_left;
    logic [EXP_W+MANT_W:0]  rez_r;
    logic                   out_valid_r;

    logic                   as_sign;
    logic [MW:0]            as_mag;
    logic [EXP_W-1:0]       exp_inc;
    logic [EXP_W-1:0]       exp_dec;
    logic [MW-1:0]          mant_sh;

    mant_addsub #(.MANT_W(MANT_W)) u_addsub (
        .semn1 (op_r[S1]),
        .mant1 (op_r[M1_HI:M1_LO]),
        .semn2 (op_r[S2]),
        .mant2 (op_r[M2_HI:0]),
        .sign  (as_sign),
        .mag   (as_mag)
    );

    // exp_in_r < EXP_MAX whenever exp_inc is used, so it cannot wrap
    assign exp_inc = exp_in_r + EXP_ONE;
    assign exp_dec = exp_r - EXP_ONE;
    assign mant_sh = {mant_r[MW-2:0], 1'b0};

    assign in_ready  = (state == ST_IDLE);
    assign rezultat  = rez_r;
    assign out_valid = out_valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_r        <= '0;
            exp_in_r    <= '0;
            exp_r       <= '0;
            mant_r      <= '0;
            sign_r      <= 1'b0;
            shift_left  <= '0;
            rez_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r     <= mantise_alin;
                        exp_in_r <= exp_mare;
                        state    <= ST_ADD;
                    end
                end

                ST_ADD: begin
                    sign_r      <= as_sign;
                    mant_r      <= as_mag[MW-1:0];
                    exp_r       <= exp_in_r;
                    shift_left  <= SHIFT_MAX;
                    state       <= ST_DONE;
                    out_valid_r <= 1'b1;
                    if (exp_in_r == EXP_INF) begin
                        rez_r <= {op_r[S1], EXP_INF, FRAC_ZERO};
                    end else if (exp_in_r == '0 || as_mag == '0) begin
                        rez_r <= '0;
                    end else if (as_mag[MW]) begin
                        if (exp_inc == EXP_INF)
                            rez_r <= {as_sign, EXP_INF, FRAC_ZERO};
                        else
                            rez_r <= {as_sign, exp_inc, as_mag[MW-1:1]};
                    end else if (as_mag[MW-1]) begin
                        rez_r <= {as_sign, exp_in_r, as_mag[MANT_W-1:0]};
                    end else begin
                        state       <= ST_NORM;
                        out_valid_r <= 1'b0;
                    end
                end

                ST_NORM: begin
                    if (exp_r == EXP_ONE && !mant_r[MW-1]) begin
                        rez_r       <= {sign_r, {(EXP_W+MANT_W){1'b0}}};
                        state       <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        mant_r     <= mant_sh;
                        exp_r      <= exp_dec;
                        shift_left <= shift_left - SHIFT_ONE;
                        // the shift budget is a backstop; a nonzero sum normalises within it
                        if (mant_sh[MW-1] || shift_left == SHIFT_ONE) begin
                            rez_r       <= {sign_r, exp_dec, mant_sh[MANT_W-1:0]};
                            state       <= ST_DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
